// File: rtl/vga_pattern_gen_if.sv
// rtl/vga_pattern_gen_if.sv - pixel position/control inputs and colour outputs of the pattern generator
interface vga_pattern_gen_if #(
  parameter int CW = 2,
  parameter int HW = 11,
  parameter int VW = 10
);
  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;
  logic [1:0]    mode_sel;
  logic          scroll_en;
  logic [CW-1:0] r;
  logic [CW-1:0] g;
  logic [CW-1:0] b;
  logic          de;
  logic [1:0]    cur_mode;
  logic [7:0]    frame_cnt;

  modport master (
    output hcount, vcount, mode_sel, scroll_en,
    input  r, g, b, de, cur_mode, frame_cnt
  );

  modport slave (
    input  hcount, vcount, mode_sel, scroll_en,
    output r, g, b, de, cur_mode, frame_cnt
  );
endinterface

// File: rtl/vga_pattern_gen.sv
// rtl/vga_pattern_gen.sv - registered VGA test-pattern generator with frame-synchronous mode/scroll
module vga_pattern_gen #(
  parameter int CW          = 2,
  parameter int HW          = 11,
  parameter int VW          = 10,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int BAND_SHIFT  = 5,
  parameter int BAR_SHIFT   = 7,
  parameter int CHECK_SHIFT = 4,
  parameter int GRAD_SHIFT  = 6,
  parameter int SCROLL_STEP = 1
) (
  input logic              clk,
  input logic              rst,
  vga_pattern_gen_if.slave bus
);
  localparam logic [31:0] N   = 32'(1) << CW;
  localparam logic [CW-1:0] MAX = '1;

  logic          fs;
  logic          active;
  logic [1:0]    mode_q, mode_eff;
  logic [7:0]    fcnt_q, fcnt_eff;
  logic [HW-1:0] off_q, off_eff, hs;
  logic [31:0]   band;
  logic [2:0]    idx;
  logic [CW-1:0] r_n, g_n, b_n;

  // On a frame-start cycle the pixel already uses the next frame's settings.
  always_comb begin
    fs       = (bus.hcount == '0) && (bus.vcount == '0);
    mode_eff = fs ? bus.mode_sel : mode_q;
    fcnt_eff = fs ? fcnt_q + 8'd1 : fcnt_q;
    off_eff  = (fs && bus.scroll_en) ? off_q + HW'(SCROLL_STEP) : off_q;
    active   = (bus.hcount < HW'(H_ACTIVE)) && (bus.vcount < VW'(V_ACTIVE));
    hs       = bus.hcount + off_eff;
    band     = 32'(bus.vcount >> BAND_SHIFT);
    idx      = 3'(hs >> BAR_SHIFT);
  end

  always_comb begin
    r_n = '0;
    g_n = '0;
    b_n = '0;
    if (active) begin
      case (mode_eff)
        2'd0: begin
          if (band < N)          r_n = CW'(band);
          else if (band < 2 * N) g_n = CW'(band - N);
          else if (band < 3 * N) b_n = CW'(band - 2 * N);
        end
        2'd1: begin
          r_n = idx[2] ? MAX : '0;
          g_n = idx[1] ? MAX : '0;
          b_n = idx[0] ? MAX : '0;
        end
        2'd2: begin
          if (!(hs[CHECK_SHIFT] ^ bus.vcount[CHECK_SHIFT])) begin
            r_n = MAX;
            g_n = MAX;
            b_n = MAX;
          end
        end
        2'd3: begin
          r_n = CW'(hs >> GRAD_SHIFT);
          g_n = CW'(bus.vcount >> GRAD_SHIFT);
          b_n = CW'(fcnt_eff);
        end
        default: begin
          r_n = '0;
          g_n = '0;
          b_n = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= '0;
      fcnt_q <= '0;
      off_q  <= '0;
      bus.r  <= '0;
      bus.g  <= '0;
      bus.b  <= '0;
      bus.de <= 1'b0;
    end else begin
      mode_q <= mode_eff;
      fcnt_q <= fcnt_eff;
      off_q  <= off_eff;
      bus.r  <= r_n;
      bus.g  <= g_n;
      bus.b  <= b_n;
      bus.de <= active;
    end
  end

  assign bus.cur_mode  = mode_q;
  assign bus.frame_cnt = fcnt_q;
endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
Parametrised VGA test-pattern generator that supersedes the fixed vertical-band colour block. It takes the timing generator's hcount/vcount and produces registered RGB plus data-enable. It supports four selectable patterns and configurable colour depth. Mode changes, horizontal scroll and a frame counter update only at frame start, so the picture never tears mid-frame.

Parameters:
CW, 2, bits per colour channel (1..8)
HW, 11, hcount width
VW, 10, vcount width
H_ACTIVE, 640, visible pixels per line
V_ACTIVE, 480, visible lines per frame
BAND_SHIFT, 5, log2 band height for mode 0 (32 lines)
BAR_SHIFT, 7, log2 bar width for mode 1 (128 px)
CHECK_SHIFT, 4, log2 checker square size for mode 2 (16 px)
GRAD_SHIFT, 6, log2 gradient step for mode 3
SCROLL_STEP, 1, offset increment per frame when scrolling

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous reset, active-high
hcount  in  HW  horizontal pixel position
vcount  in  VW  vertical line position
mode_sel  in  2  requested pattern; sampled only at frame start
scroll_en  in  1  enables offset advance at frame start
r  out  CW  red
g  out  CW  green
b  out  CW  blue
de  out  1  active-video flag, aligned with r/g/b
cur_mode  out  2  pattern currently displayed
frame_cnt  out  8  frame counter

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). All outputs are registered.
- Reset values: r=g=b=0, de=0, cur_mode=0, frame_cnt=0, internal offset (HW bits)=0. Reset has priority over every other event, including a frame-start cycle.
- Latency: 1 cycle. Outputs at cycle N+1 reflect hcount/vcount presented at cycle N.
- Frame start (FS): the cycle where hcount==0 and vcount==0. On FS:
  - cur_mode <= mode_sel.
  - frame_cnt <= frame_cnt+1, wrapping 255->0.
  - offset <= offset+SCROLL_STEP if scroll_en, otherwise unchanged. The sum is truncated to HW bits, so it wraps mod 2^HW.
- Effective values: in an FS cycle, the pixel computation uses the next-state mode, offset and frame_cnt. In all other cycles it uses the registered values. Pixel (0,0) is therefore always drawn with the new frame's settings.
- Blanking: hcount>=H_ACTIVE or vcount>=V_ACTIVE gives r=g=b=0 and de=0. Otherwise de=1.
- MAX = all-ones in CW bits. hs = (hcount+offset) truncated to HW bits.
- Mode 0, vertical bands:
  - band = vcount>>BAND_SHIFT; N = 2^CW.
  - band<N: r=band[CW-1:0].
  - N<=band<2N: g=band-N.
  - 2N<=band<3N: b=band-2N.
  - band>=3N: black.
  - Unselected channels are 0. Offset is ignored.
- Mode 1, colour bars:
  - idx = (hs>>BAR_SHIFT)[2:0].
  - r = idx[2]?MAX:0, g = idx[1]?MAX:0, b = idx[0]?MAX:0.
- Mode 2, checker:
  - c = (hs>>CHECK_SHIFT)[0] XOR (vcount>>CHECK_SHIFT)[0].
  - c==0 gives r=g=b=MAX (white); c==1 gives black.
- Mode 3, gradient:
  - r = (hs>>GRAD_SHIFT)[CW-1:0]
  - g = (vcount>>GRAD_SHIFT)[CW-1:0]
  - b = frame_cnt[CW-1:0], using the effective frame_cnt.
- mode_sel and scroll_en changes between FS cycles have no visible effect until the next FS.
- Default case: outputs 0, so no latches and no stale colour.
- Non-contiguous hcount/vcount (e.g. a timing generator reset) is tolerated. Each pixel is a pure function of the current inputs and the registered state.

Test Plan:
1. Reset: rst=1 for 2 cycles with hcount=100, vcount=100 -> r=g=b=0, de=0, cur_mode=0, frame_cnt=0; rst held during an FS cycle -> frame_cnt stays 0.
2. Mode 0 (CW=2), one cycle after each input:
   - vcount=40, hcount=10 -> r=1, g=0, b=0, de=1.
   - vcount=250 -> g=3.
   - vcount=300 -> b=1.
   - vcount=400 -> r=g=b=0, de=1.
3. Blanking:
   - hcount=640, vcount=10 -> r=g=b=0, de=0.
   - vcount=480 -> de=0.
4. Mode switch:
   - mode_sel 0->2 at (300,200) -> cur_mode stays 0 and mode-0 colours continue.
   - At (0,0) -> cur_mode=2 and pixel is white.
   - At (16,0) -> black; at (16,16) -> white.
5. Scroll, mode 1, scroll_en=1, SCROLL_STEP=1:
   - After 3 FS cycles, offset=3 and frame_cnt=3.
   - hcount=125 -> hs=128, idx=1 -> r=0, g=0, b=3.
   - scroll_en=0 for the next FS -> offset stays 3.
6. Wrap:
   - 256 FS cycles -> frame_cnt returns to 0.
   - SCROLL_STEP=1024 -> offset sequence 0, 1024, 0.
   - Mode 3 at hcount=0, vcount=64 -> b=frame_cnt[1:0], g=1.
